// File: rtl/translator_bank_scanner.sv
// Walks the translator banks one at a time: enable, settle, sample against an expected pattern,
// then break-before-make to the next bank. Accumulates a per-bank fail mask and an error-bit count.
module translator_bank_scanner #(
    parameter int unsigned NUM_BANKS     = 8,
    parameter int unsigned BANK_W        = 7,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned ERR_W         = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BANK_W-1:0]           expected,
    input  logic [NUM_BANKS*BANK_W-1:0] data_bit,
    output logic [NUM_BANKS-1:0]        enable_bit,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [NUM_BANKS-1:0]        fail_mask,
    output logic [2:0]                  bank_idx,
    output logic [ERR_W-1:0]            err_count
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StSample = 3'd2;
    localparam logic [2:0] StGap    = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  LastBank   = 3'(NUM_BANKS - 1);

    logic [2:0]                  state_q, state_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [2:0]                  bank_q, bank_d;
    logic [NUM_BANKS-1:0]        en_q, en_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        pass_q, pass_d;
    logic [NUM_BANKS-1:0]        fail_q, fail_d;
    logic [ERR_W-1:0]            err_q, err_d;
    logic [NUM_BANKS*BANK_W-1:0] sync1_q, sync2_q;
    logic [BANK_W-1:0]           mm;

    function automatic logic [ERR_W-1:0] popcount(input logic [BANK_W-1:0] v);
        logic [ERR_W-1:0] c;
        c = '0;
        for (int i = 0; i < BANK_W; i++) begin
            c = c + ERR_W'(v[i]);
        end
        return c;
    endfunction

    // Pins come from another clock domain's world; the settle time absorbs this latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= data_bit;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        mm = sync2_q[bank_q*BANK_W +: BANK_W] ^ expected;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    fail_d  = '0;
                    err_d   = '0;
                    bank_d  = '0;
                    en_d    = NUM_BANKS'(1);
                    busy_d  = 1'b1;
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == 16'd0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StSample: begin
                if (mm != '0) begin
                    fail_d[bank_q] = 1'b1;
                end
                err_d   = err_q + popcount(mm);
                en_d    = '0;
                state_d = StGap;
            end
            StGap: begin
                if (bank_q == LastBank) begin
                    done_d  = 1'b1;
                    // fail_mask is final here, so pass is valid alongside the done pulse.
                    pass_d  = (fail_q == '0);
                    state_d = StDone;
                end else begin
                    bank_d  = bank_q + 3'd1;
                    en_d    = NUM_BANKS'(1) << (bank_q + 3'd1);
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                en_d    = '0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bank_q  <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    assign enable_bit = en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_mask  = fail_q;
    assign bank_idx   = bank_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_translator_bank_scanner.sv
// Scoreboard bench for translator_bank_scanner: expected scan results are queued at start and
// compared when done pulses; a negedge monitor checks enable sequencing continuously.
module tb_translator_bank_scanner;

    localparam int NB = 8;
    localparam int BW = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [BW-1:0]   expected = '0;
    logic [NB*BW-1:0] data_bit = '0;
    logic [NB-1:0]   enable_bit;
    logic            busy, done, pass;
    logic [NB-1:0]   fail_mask;
    logic [2:0]      bank_idx;
    logic [5:0]      err_count;

    translator_bank_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .expected   (expected),
        .data_bit   (data_bit),
        .enable_bit (enable_bit),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_mask  (fail_mask),
        .bank_idx   (bank_idx),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] fm;
        logic [5:0]    ec;
        logic          ps;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   last_rise = 0;
    int   last_done_cyc = 0;
    int   done_cnt = 0;
    int   exp_bank = 0;
    logic [NB-1:0] prev_en = '0;
    logic prev_busy = 1'b0;
    logic pass_pending = 1'b0;
    logic pass_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [NB*BW-1:0] d, input logic [BW-1:0] e);
        exp_t r;
        int   ec;
        logic [BW-1:0] mm;
        r.fm = '0;
        ec = 0;
        for (int b = 0; b < NB; b++) begin
            mm = d[b*BW +: BW] ^ e;
            if (mm != '0) r.fm[b] = 1'b1;
            ec += $countones(mm);
        end
        r.ec = 6'(ec);
        r.ps = (r.fm == '0);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_en = '0;
            prev_busy = 1'b0;
            exp_bank = 0;
            pass_pending = 1'b0;
        end else begin
            chk("onehot0", 64'($onehot0(enable_bit)), 64'd1);
            chk("break_before_make",
                64'(prev_en != '0 && enable_bit != '0 && enable_bit != prev_en), 64'd0);
            if (pass_pending) begin
                chk("pass", 64'(pass), 64'(pass_exp));
                pass_pending = 1'b0;
            end
            if (busy && !prev_busy) begin
                accept_cyc = cyc;
                exp_bank = 0;
                chk("err_clear_at_start", 64'(err_count), 64'd0);
                chk("mask_clear_at_start", 64'(fail_mask), 64'd0);
            end
            if (enable_bit != '0 && prev_en == '0) begin
                chk("bank_enable", 64'(enable_bit), 64'(1) << exp_bank);
                chk("bank_idx", 64'(bank_idx), 64'(exp_bank));
                if (exp_bank != 0) chk("bank_period", 64'(cyc - last_rise), 64'd66);
                last_rise = cyc;
                exp_bank++;
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_latency", 64'(cyc - accept_cyc), 64'd528);
                chk("banks_visited", 64'(exp_bank), 64'd8);
                chk("busy_in_done", 64'(busy), 64'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("fail_mask", 64'(fail_mask), 64'(e.fm));
                    chk("err_count", 64'(err_count), 64'(e.ec));
                    pass_pending = 1'b1;
                    pass_exp = e.ps;
                end
            end
            prev_en = enable_bit;
            prev_busy = busy;
        end
    end

    // Called at a negedge; start is presented for exactly one rising edge.
    task automatic do_scan(input logic [NB*BW-1:0] d, input logic [BW-1:0] e);
        data_bit = d;
        expected = e;
        sb.push_back(model(d, e));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n0 = done_cnt;
        for (int i = 0; i < 700 && done_cnt == n0; i++) @(negedge clk);
        chk("done_timeout", 64'(done_cnt != n0), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_bank(input logic [2:0] b);
        int i;
        for (i = 0; i < 700 && !(bank_idx == b && enable_bit != '0); i++) @(negedge clk);
        chk("bank_wait_timeout", 64'(i < 700), 64'd1);
    endtask

    logic [NB*BW-1:0] ones;
    logic [NB*BW-1:0] stuck;
    logic [NB*BW-1:0] rnd;
    int d1, n1;

    initial begin
        ones = '1;
        stuck = '1;
        stuck[3*BW + 2] = 1'b0;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk("rst_enable", 64'(enable_bit), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fail_mask", 64'(fail_mask), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_bank_idx", 64'(bank_idx), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_scan(ones, 7'h7F);  wait_done();
        do_scan(stuck, 7'h7F); wait_done();
        do_scan('0, 7'h7F);    wait_done();

        // start pulse mid-scan must be ignored
        n1 = done_cnt;
        do_scan(ones, 7'h7F);
        wait_bank(3'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("single_done", 64'(done_cnt - n1), 64'd1);
        chk("idle_after_scan", 64'(busy), 64'd0);

        // start held high: back-to-back scans separated by one idle cycle
        data_bit = '0;
        expected = 7'h7F;
        sb.push_back(model('0, 7'h7F));
        sb.push_back(model(ones, 7'h7F));
        start = 1'b1;
        wait_done();
        d1 = last_done_cyc;
        data_bit = ones;
        for (int i = 0; i < 10 && accept_cyc <= d1; i++) @(negedge clk);
        start = 1'b0;
        chk("held_start_gap", 64'(accept_cyc - d1), 64'd2);
        wait_done();

        // Reset mid-scan while bank 4 is settling
        do_scan(stuck, 7'h7F);
        wait_bank(3'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_enable", 64'(enable_bit), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_pass", 64'(pass), 64'd0);
        chk("midrst_err", 64'(err_count), 64'd0);
        sb.delete();
        n1 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - n1), 64'd0);

        rnd = {$urandom(), $urandom()};
        do_scan(rnd, 7'h2A);   wait_done();
        do_scan(ones, 7'h7F);  wait_done();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
